// File: rtl/debug_ctrl_pkg.sv
// Shared types and constants for the ILA debug capture sequencer.
// Bit positions refer to the raw VIO control word.
package debug_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_ARMED   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    localparam int VIO_SEL_HI   = 15;
    localparam int VIO_SEL_LO   = 8;
    localparam int VIO_AUTO     = 7;
    localparam int VIO_ARM      = 6;
    localparam int VIO_ABORT    = 5;

    localparam int SEL_BASE_DEF = 19;

endpackage

// File: rtl/debug_rr_pick.sv
// Round-robin finder: lowest set mask bit (first mode) or the next set bit
// strictly after cur_i, wrapping so cur_i itself is the last candidate.
module debug_rr_pick #(
    parameter int NUM_GRP = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_GRP-1:0] mask_i,
    input  logic [IDX_W-1:0]   cur_i,
    input  logic               first_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               none_valid_o
);

    logic [IDX_W:0]   base;
    logic [IDX_W-1:0] cand [NUM_GRP];
    logic [NUM_GRP-1:0] hit;

    assign base = first_i ? '0 : ({1'b0, cur_i} + (IDX_W+1)'(1));

    // Candidate gi is the gi-th index visited from base, folded back into range.
    generate
        for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = base + (IDX_W+1)'(gi);
            assign cand[gi] = (sum >= (IDX_W+1)'(NUM_GRP))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_GRP))
                            : IDX_W'(sum);
            assign hit[gi] = mask_i[cand[gi]];
        end
    endgenerate

    always_comb begin
        idx_o        = '0;
        none_valid_o = 1'b1;
        for (int k = NUM_GRP - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx_o        = cand[k];
                none_valid_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/debug_capture_ctrl.sv
// Debug group sequencer: selects a probe group (manual or round-robin) and runs
// settle / arm / trigger / post-trigger capture windows, reporting to VIO.
module debug_capture_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int NUM_GRP    = 8,
    parameter int SEL_W      = 8,
    parameter int SEL_BASE   = SEL_BASE_DEF,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 16
) (
    input  logic               clk_100mhz,
    input  logic               sys_rst,
    input  logic [15:0]        vio_ctrl,
    input  logic [NUM_GRP-1:0] grp_enable,
    input  logic [NUM_GRP-1:0] grp_trig,
    input  logic [WIN_W-1:0]   post_len,
    output logic [SEL_W-1:0]   dbg_sel,
    output logic               cap_en,
    output logic               cap_trig,
    output logic               done,
    output logic               busy,
    output logic               sel_err,
    output logic [WIN_W-1:0]   win_cnt
);

    localparam int IDX_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    logic [15:0]      sync1_q, sync2_q;
    logic             arm_dly_q;
    state_e           state_q;
    logic [IDX_W-1:0] grp_q;
    logic             auto_q;
    logic [SET_W-1:0] settle_q;
    logic [WIN_W-1:0] rem_q;
    logic [SEL_W-1:0] dbg_sel_q;
    logic             cap_en_q, cap_trig_q, done_q, sel_err_q;
    logic [WIN_W-1:0] win_cnt_q;

    logic             arm_rise, abort_lvl, auto_req;
    logic [SEL_W-1:0] man_code, man_off;
    logic             man_valid;
    logic [IDX_W-1:0] man_grp, pick_idx;
    logic             pick_none, trig_hit;
    logic [WIN_W-1:0] eff_len;
    logic             unused_vio_bits;

    assign arm_rise        = sync2_q[VIO_ARM] & ~arm_dly_q;
    assign abort_lvl       = sync2_q[VIO_ABORT];
    assign auto_req        = sync2_q[VIO_AUTO];
    assign unused_vio_bits = ^sync2_q[4:0];

    assign man_code  = SEL_W'(sync2_q[VIO_SEL_HI:VIO_SEL_LO]);
    assign man_off   = man_code - SEL_W'(SEL_BASE);
    assign man_valid = (man_code >= SEL_W'(SEL_BASE)) && (man_off < SEL_W'(NUM_GRP));
    assign man_grp   = IDX_W'(man_off);

    assign trig_hit = grp_trig[grp_q];
    assign eff_len  = (post_len == '0) ? WIN_W'(1) : post_len;

    // In IDLE the finder starts from index 0; otherwise it advances past grp_q.
    debug_rr_pick #(
        .NUM_GRP (NUM_GRP),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .mask_i       (grp_enable),
        .cur_i        (grp_q),
        .first_i      (state_q == ST_IDLE),
        .idx_o        (pick_idx),
        .none_valid_o (pick_none)
    );

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            arm_dly_q  <= 1'b0;
            state_q    <= ST_IDLE;
            grp_q      <= '0;
            auto_q     <= 1'b0;
            settle_q   <= '0;
            rem_q      <= '0;
            dbg_sel_q  <= SEL_W'(SEL_BASE);
            cap_en_q   <= 1'b0;
            cap_trig_q <= 1'b0;
            done_q     <= 1'b0;
            sel_err_q  <= 1'b0;
            win_cnt_q  <= '0;
        end else begin
            sync1_q    <= vio_ctrl;
            sync2_q    <= sync1_q;
            arm_dly_q  <= sync2_q[VIO_ARM];
            cap_trig_q <= 1'b0;

            if (abort_lvl) begin
                state_q  <= ST_IDLE;
                cap_en_q <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        done_q <= 1'b0;
                        if (arm_rise) begin
                            if (auto_req) begin
                                if (!pick_none) begin
                                    grp_q     <= pick_idx;
                                    auto_q    <= 1'b1;
                                    dbg_sel_q <= SEL_W'(SEL_BASE) + SEL_W'(pick_idx);
                                    settle_q  <= '0;
                                    state_q   <= ST_SETTLE;
                                end
                            end else if (man_valid) begin
                                grp_q     <= man_grp;
                                auto_q    <= 1'b0;
                                sel_err_q <= 1'b0;
                                dbg_sel_q <= SEL_W'(SEL_BASE) + SEL_W'(man_grp);
                                settle_q  <= '0;
                                state_q   <= ST_SETTLE;
                            end else begin
                                sel_err_q <= 1'b1;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                            state_q <= ST_ARMED;
                        end else begin
                            settle_q <= settle_q + SET_W'(1);
                        end
                    end
                    ST_ARMED: begin
                        if (trig_hit) begin
                            rem_q      <= eff_len;
                            cap_en_q   <= 1'b1;
                            cap_trig_q <= 1'b1;
                            done_q     <= (eff_len == WIN_W'(1));
                            state_q    <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        // rem_q counts the capture cycles still to go, including this one.
                        if (rem_q == WIN_W'(1)) begin
                            cap_en_q  <= 1'b0;
                            done_q    <= 1'b0;
                            win_cnt_q <= win_cnt_q + WIN_W'(1);
                            if (auto_q && !pick_none) begin
                                grp_q     <= pick_idx;
                                dbg_sel_q <= SEL_W'(SEL_BASE) + SEL_W'(pick_idx);
                                settle_q  <= '0;
                                state_q   <= ST_SETTLE;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            rem_q  <= rem_q - WIN_W'(1);
                            done_q <= (rem_q == WIN_W'(2));
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign dbg_sel  = dbg_sel_q;
    assign cap_en   = cap_en_q;
    assign cap_trig = cap_trig_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);
    assign sel_err  = sel_err_q;
    assign win_cnt  = win_cnt_q;

endmodule

// File: tb/tb_debug_capture_ctrl.sv
// Directed bench for debug_capture_ctrl: manual, invalid, auto round-robin,
// abort, re-arm during capture and reset scenarios with hand-computed cycles.
module tb_debug_capture_ctrl;

    logic        clk_100mhz = 1'b0;
    logic        sys_rst    = 1'b1;
    logic [15:0] vio_ctrl   = '0;
    logic [7:0]  grp_enable = '0;
    logic [7:0]  grp_trig   = '0;
    logic [15:0] post_len   = '0;

    logic [7:0]  dbg_sel;
    logic        cap_en, cap_trig, done, busy, sel_err;
    logic [15:0] win_cnt;

    int n_vec  = 0;
    int n_err  = 0;
    int n_trig = 0;
    int n_done = 0;

    debug_capture_ctrl dut (
        .clk_100mhz (clk_100mhz),
        .sys_rst    (sys_rst),
        .vio_ctrl   (vio_ctrl),
        .grp_enable (grp_enable),
        .grp_trig   (grp_trig),
        .post_len   (post_len),
        .dbg_sel    (dbg_sel),
        .cap_en     (cap_en),
        .cap_trig   (cap_trig),
        .done       (done),
        .busy       (busy),
        .sel_err    (sel_err),
        .win_cnt    (win_cnt)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    always @(negedge clk_100mhz) begin
        if (cap_trig) n_trig <= n_trig + 1;
        if (done)     n_done <= n_done + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_code(input logic [7:0] code, input logic auto_m);
        vio_ctrl[15:8] = code;
        vio_ctrl[7]    = auto_m;
    endtask

    // Leaves arm high at the current cycle; arm_rise reaches the FSM two edges later.
    task automatic arm_edge();
        vio_ctrl[6] = 1'b0;
        tick(3);
        vio_ctrl[6] = 1'b1;
    endtask

    initial begin
        int t0, d0;
        int exp_sel [6] = '{21, 24, 26, 21, 24, 26};

        tick(3);
        check_val("rst_dbg_sel", dbg_sel, 19);
        check_val("rst_cap_en", cap_en, 0);
        check_val("rst_cap_trig", cap_trig, 0);
        check_val("rst_done", done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_sel_err", sel_err, 0);
        check_val("rst_win_cnt", win_cnt, 0);
        sys_rst = 1'b0;
        tick(1);

        // Manual code 21, post_len 4, trigger on group 2
        set_code(8'd21, 1'b0);
        post_len = 16'd4;
        arm_edge();
        tick(2);
        check_val("arm_lat_early", busy, 0);
        tick(1);
        check_val("arm_lat_busy", busy, 1);
        check_val("man_dbg_sel", dbg_sel, 21);
        tick(15);
        grp_trig = 8'h04;
        tick(1);
        check_val("settle_trig_ignored", cap_en, 0);
        t0 = n_trig;
        d0 = n_done;
        tick(1);
        grp_trig = 8'h00;
        check_val("man_cap_en_first", cap_en, 1);
        check_val("man_cap_trig", cap_trig, 1);
        check_val("man_done_early", done, 0);
        tick(2);
        check_val("man_cap_en_mid", cap_en, 1);
        check_val("man_done_mid", done, 0);
        tick(1);
        check_val("man_cap_en_last", cap_en, 1);
        check_val("man_done_last", done, 1);
        tick(1);
        check_val("man_cap_en_end", cap_en, 0);
        check_val("man_busy_end", busy, 0);
        check_val("man_win_cnt", win_cnt, 1);
        check_val("man_trig_pulses", n_trig - t0, 1);
        check_val("man_done_pulses", n_done - d0, 1);
        $display("window manual sel=%0d win_cnt=%0d", dbg_sel, win_cnt);

        // Invalid manual code 40, then valid code 19 with post_len 0
        set_code(8'd40, 1'b0);
        arm_edge();
        tick(4);
        check_val("bad_sel_err", sel_err, 1);
        check_val("bad_busy", busy, 0);
        set_code(8'd19, 1'b0);
        arm_edge();
        tick(3);
        check_val("good_busy", busy, 1);
        check_val("good_sel_err", sel_err, 0);
        check_val("good_dbg_sel", dbg_sel, 19);
        post_len = 16'd0;
        grp_trig = 8'hFF;
        tick(16);
        check_val("settle_trig_ignored2", cap_en, 0);
        grp_trig = 8'h00;
        tick(1);
        check_val("armed_no_trig", cap_en, 0);
        grp_trig = 8'h01;
        d0 = n_done;
        tick(1);
        grp_trig = 8'h00;
        check_val("len0_cap_en", cap_en, 1);
        check_val("len0_cap_trig", cap_trig, 1);
        check_val("len0_done", done, 1);
        tick(1);
        check_val("len0_cap_en_off", cap_en, 0);
        check_val("len0_busy", busy, 0);
        check_val("len0_win_cnt", win_cnt, 2);
        $display("window len0 sel=%0d win_cnt=%0d", dbg_sel, win_cnt);

        // Auto round-robin over groups 2, 5, 7
        grp_enable = 8'b1010_0100;
        post_len   = 16'd2;
        grp_trig   = 8'hFF;
        set_code(8'd0, 1'b1);
        t0 = n_trig;
        arm_edge();
        tick(3);
        check_val("auto_busy", busy, 1);
        tick(17);
        for (int i = 0; i < 6; i++) begin
            check_val("auto_trig", cap_trig, 1);
            check_val("auto_sel", dbg_sel, exp_sel[i]);
            $display("window auto %0d sel=%0d", i, dbg_sel);
            if (i == 5) grp_enable = 8'h00;
            tick(1);
            check_val("auto_done", done, 1);
            tick(1);
            if (i < 5) begin
                check_val("auto_next_sel", dbg_sel, exp_sel[i + 1]);
                check_val("auto_next_busy", busy, 1);
                tick(17);
            end else begin
                check_val("auto_stop_busy", busy, 0);
                check_val("auto_stop_sel", dbg_sel, 26);
            end
        end
        grp_trig = 8'h00;
        tick(20);
        check_val("auto_idle_busy", busy, 0);
        check_val("auto_win_cnt", win_cnt, 8);
        check_val("auto_trig_pulses", n_trig - t0, 6);
        vio_ctrl[7] = 1'b0;

        // Abort mid-capture with post_len 100
        set_code(8'd22, 1'b0);
        post_len = 16'd100;
        arm_edge();
        tick(3);
        check_val("abort_dbg_sel", dbg_sel, 22);
        tick(16);
        grp_trig = 8'h08;
        tick(1);
        grp_trig = 8'h00;
        check_val("abort_cap_start", cap_en, 1);
        tick(5);
        d0 = n_done;
        vio_ctrl[5] = 1'b1;
        tick(2);
        check_val("abort_sync_lat", cap_en, 1);
        tick(1);
        check_val("abort_cap_en", cap_en, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        tick(2);
        check_val("abort_no_done", n_done - d0, 0);
        check_val("abort_win_cnt", win_cnt, 8);
        vio_ctrl[5] = 1'b0;
        $display("window abort sel=%0d win_cnt=%0d", dbg_sel, win_cnt);

        // Second arm edge during capture is ignored
        set_code(8'd20, 1'b0);
        post_len = 16'd10;
        arm_edge();
        tick(3);
        check_val("rearm_busy", busy, 1);
        tick(16);
        grp_trig = 8'h02;
        d0 = n_done;
        tick(1);
        grp_trig = 8'h00;
        check_val("rearm_cap_trig", cap_trig, 1);
        vio_ctrl[6] = 1'b0;
        tick(3);
        vio_ctrl[6] = 1'b1;
        tick(5);
        check_val("rearm_still_cap", cap_en, 1);
        tick(2);
        check_val("rearm_end_busy", busy, 0);
        check_val("rearm_win_cnt", win_cnt, 9);
        tick(25);
        check_val("rearm_idle_busy", busy, 0);
        check_val("rearm_done_pulses", n_done - d0, 1);
        check_val("rearm_win_cnt2", win_cnt, 9);
        $display("window rearm sel=%0d win_cnt=%0d", dbg_sel, win_cnt);

        // Reset while ARMED
        set_code(8'd23, 1'b0);
        post_len = 16'd4;
        arm_edge();
        tick(3);
        check_val("rstarm_dbg_sel", dbg_sel, 23);
        tick(16);
        check_val("rstarm_busy_pre", busy, 1);
        sys_rst  = 1'b1;
        vio_ctrl = '0;
        tick(1);
        check_val("rstarm_dbg_sel_rst", dbg_sel, 19);
        check_val("rstarm_busy", busy, 0);
        check_val("rstarm_win_cnt", win_cnt, 0);
        check_val("rstarm_cap_en", cap_en, 0);
        check_val("rstarm_done", done, 0);
        check_val("rstarm_sel_err", sel_err, 0);
        sys_rst = 1'b0;
        tick(3);
        check_val("rstarm_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debug_capture_ctrl.md
# debug_capture_ctrl

Sequencer for the ILA debug path. It synchronizes the VIO control word and selects which debug group drives the ILA probe mux, either manually or round-robin over enabled groups. For each selection it runs a settle, arm, trigger, post-trigger capture sequence and reports status back to VIO. It sits between the VIO core and the debug-group/clock mux in the debug block.

## Interface
- NUM_GRP, 8, number of debug groups (max 16)
- SEL_W, 8, width of mux select code
- SEL_BASE, 19, select code of group 0; group i uses code SEL_BASE+i
- WIN_W, 16, width of post-trigger length and counters
- SETTLE_CYC, 16, cycles to wait after a select change before arming (≥1)

Ports:
- clk_100mhz  in  1  sole clock
- sys_rst  in  1  synchronous, active-high reset
- vio_ctrl  in  16  async VIO word: [15:8] manual select code, [7] auto_mode, [6] arm, [5] abort, [4:0] ignored
- grp_enable  in  NUM_GRP  auto-mode participation mask, synchronous
- grp_trig  in  NUM_GRP  per-group trigger pulses, synchronous
- post_len  in  WIN_W  samples captured after trigger; 0 treated as 1
- dbg_sel  out  SEL_W  mux select code
- cap_en  out  1  high during capture window
- cap_trig  out  1  one-cycle pulse on first capture cycle
- done  out  1  one-cycle pulse when a window completes
- busy  out  1  state ≠ IDLE
- sel_err  out  1  sticky: manual arm with invalid code
- win_cnt  out  WIN_W  completed windows, wraps

## Operation
- vio_ctrl passes through a 2-flop synchronizer, then a third register for arm edge detect. arm_rise = s2[6] & ~s3[6].
- States: IDLE, SETTLE, ARMED, CAPTURE.
- IDLE, arm_rise:
  - Manual mode: grp = code − SEL_BASE. If code < SEL_BASE or grp ≥ NUM_GRP, set sel_err and stay IDLE. Otherwise latch grp and go SETTLE.
  - Auto mode: pick the lowest enabled index. If grp_enable = 0, stay IDLE with no error.
- SETTLE: dbg_sel = SEL_BASE+grp. Count SETTLE_CYC cycles, then go ARMED.
- ARMED: grp_trig[grp] sampled only while state = ARMED. On trigger, go CAPTURE and latch len = max(post_len, 1).
- CAPTURE: cap_en high for exactly len cycles. On the last cycle, pulse done, increment win_cnt, then:
  - Manual: go IDLE.
  - Auto: pick the next enabled index strictly after grp, wrapping (reselect grp if it is the only one). Go SETTLE. If grp_enable = 0, go IDLE.
- abort (synced level) in any state: next cycle IDLE, cap_en = 0, no done, win_cnt unchanged. Abort has priority over all transitions.
- arm_rise while busy is ignored. Manual code changes while busy take effect at the next arm.
- sel_err clears on a valid manual arm or on reset.
- dbg_sel holds its last value in IDLE.

## Timing
- Reset values: dbg_sel = SEL_BASE, cap_en = 0, cap_trig = 0, done = 0, busy = 0, sel_err = 0, win_cnt = 0, state = IDLE, synchronizers = 0.
- vio arm rising at the input before edge N → busy and SETTLE visible at cycle N+3.
- SETTLE entered at cycle S → ARMED at S+SETTLE_CYC.
- Trigger high at ARMED cycle T → cap_en and cap_trig at T+1. cap_en falls at T+1+len. done coincides with the last cap_en cycle.
- Auto: next SETTLE begins the cycle after done.
- sys_rst mid-capture: all outputs reach reset values on the next edge.

## Structure
- Package debug_ctrl_pkg holds:
  - state enum (2 bits)
  - VIO bit positions (SEL_HI=15, SEL_LO=8, AUTO=7, ARM=6, ABORT=5)
  - SEL_BASE default
- Sub-module debug_rr_pick: combinational round-robin next-index finder. Inputs: mask, current index, first-mode flag. Outputs: index, none_valid.

## Test plan
- Manual code 21, arm, SETTLE_CYC=16, post_len=4, trigger grp 2 → dbg_sel=21; cap_en 4 cycles starting 1 cycle after trigger; one cap_trig and one done pulse; win_cnt=1; back to IDLE.
- Manual code 40 (invalid), arm → sel_err=1, busy stays 0. Then code 19 and arm → sel_err=0, SETTLE.
- Auto, grp_enable=8'b1010_0100 → sequence of dbg_sel 21, 24, 26, 21 with a trigger each window. Clear the mask during the window on 26 → that window completes, then IDLE.
- post_len=0 → exactly 1 cap_en cycle. Trigger pulses during SETTLE → ignored, no capture.
- abort asserted mid-CAPTURE with post_len=100 → cap_en low within synchronizer latency+1, no done, win_cnt unchanged. sys_rst mid-ARMED → all reset values next cycle.
- Second arm edge during CAPTURE → ignored; win_cnt increments by exactly 1.
